// File: rtl/mult_pkg.sv
// Shared constants for the sequential 8x8 multiplier:
// state encoding, step codes and datapath widths.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] CODE_IDLE = 3'b100;
  localparam logic [2:0] CODE_DONE = 3'b101;

  function automatic logic [2:0] step_code(
    input logic [1:0] st,
    input logic [1:0] cnt
  );
    logic [2:0] c;
    c = CODE_IDLE;
    unique case (1'b1)
      (st == S_CALC): c = {1'b0, cnt};
      (st == S_DONE): c = CODE_DONE;
      default:        c = CODE_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult8x8_seq_if.sv
// Handshake and data bundle between the datapath master
// and the sequential multiplier.
interface mult8x8_seq_if;
  import mult_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [PROD_W-1:0] product;
  logic              done;
  logic              busy;
  logic [2:0]        binary;

  modport master (
    output start, a, b,
    input  product, done, busy, binary
  );

  modport slave (
    input  start, a, b,
    output product, done, busy, binary
  );
endinterface

// File: rtl/mult4x4.sv
// Combinational 4x4 -> 8 unsigned multiplier, one
// partial product per compute step.
module mult4x4
  import mult_pkg::*;
(
  input  logic [NIB_W-1:0]   x,
  input  logic [NIB_W-1:0]   y,
  output logic [2*NIB_W-1:0] p
);
  assign p = {4'h0, x} * {4'h0, y};
endmodule

// File: rtl/mult8x8_seq.sv
// Sequential 8x8 unsigned multiplier: four 4x4 partial
// products accumulated over four CALC cycles.
module mult8x8_seq
  import mult_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mult8x8_seq_if.slave bus
);

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [PROD_W-1:0] acc;

  logic [NIB_W-1:0]   nib_a;
  logic [NIB_W-1:0]   nib_b;
  logic [2*NIB_W-1:0] pp;
  logic [3:0]         sh;
  logic [PROD_W-1:0]  pp_sh;

  // cnt[0] picks the high nibble of a, cnt[1] that of b
  assign nib_a = cnt[0] ? a_q[7:4] : a_q[3:0];
  assign nib_b = cnt[1] ? b_q[7:4] : b_q[3:0];

  mult4x4 u_pp (
    .x (nib_a),
    .y (nib_b),
    .p (pp)
  );

  always_comb begin
    sh = 4'd0;
    unique case (1'b1)
      (cnt == 2'd0): sh = 4'd0;
      (cnt == 2'd3): sh = 4'd8;
      default:       sh = 4'd4;
    endcase
  end

  assign pp_sh = {8'h00, pp} << sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_CALC): begin
          acc <= acc + pp_sh;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3)
            state <= S_DONE;
        end
        default: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc   <= '0;
            cnt   <= 2'd0;
            state <= S_CALC;
          end
        end
      endcase
    end
  end

  assign bus.product = acc;
  assign bus.done    = (state == S_DONE);
  assign bus.busy    = (state == S_CALC);
  assign bus.binary  = step_code(state, cnt);

endmodule

// File: tb/tb_mult8x8_seq.sv
// Directed and randomized checks of mult8x8_seq against
// a plain a*b reference and the step-code sequence.
module tb_mult8x8_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mult8x8_seq_if bus ();

  mult8x8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".product"}, bus.product, 16'h0000);
    chk({tag, ".done"}, {15'd0, bus.done}, 16'd0);
    chk({tag, ".busy"}, {15'd0, bus.busy}, 16'd0);
    chk({tag, ".binary"}, {13'd0, bus.binary}, 16'd4);
  endtask

  task automatic chk_done(input string tag, input logic [15:0] exp);
    chk({tag, ".done"}, {15'd0, bus.done}, 16'd1);
    chk({tag, ".busy"}, {15'd0, bus.busy}, 16'd0);
    chk({tag, ".binary"}, {13'd0, bus.binary}, 16'd5);
    chk({tag, ".product"}, bus.product, exp);
  endtask

  // Start one operation and follow it through CALC to DONE.
  task automatic do_op(
    input string      tag,
    input logic [7:0] x,
    input logic [7:0] y,
    input bit         disturb
  );
    logic [15:0] exp;
    exp = 16'(x) * 16'(y);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy"}, {15'd0, bus.busy}, 16'd1);
      chk({tag, ".done_lo"}, {15'd0, bus.done}, 16'd0);
      chk({tag, ".step"}, {13'd0, bus.binary}, 16'(i));
      if (disturb) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.start = 1'($urandom);
      end
      tick();
    end
    bus.start = 1'b0;
    chk_done(tag, exp);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;

    tick();
    tick();
    tick();
    chk_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_reset("rst_rel");

    do_op("m12x34", 8'h12, 8'h34, 1'b0);
    do_op("mffxff", 8'hFF, 8'hFF, 1'b0);
    do_op("m00xa7", 8'h00, 8'hA7, 1'b0);
    do_op("m01x01", 8'h01, 8'h01, 1'b0);

    // restart pulse while cnt=1 must be ignored
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("ign.step1", {13'd0, bus.binary}, 16'd1);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign.step2", {13'd0, bus.binary}, 16'd2);
    tick();
    chk("ign.step3", {13'd0, bus.binary}, 16'd3);
    tick();
    chk_done("ign", 16'h03A8);

    // back-to-back from DONE
    bus.a = 8'h10;
    bus.b = 8'h10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("b2b.done_drop", {15'd0, bus.done}, 16'd0);
    chk("b2b.busy", {15'd0, bus.busy}, 16'd1);
    tick();
    tick();
    tick();
    tick();
    chk_done("b2b", 16'h0100);

    // asynchronous reset at cnt=2
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("mid.step2", {13'd0, bus.binary}, 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset("mid_rel");

    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op("rand", ra, rb, 1'b1);
      if ($urandom_range(0, 1) == 1)
        tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult8x8_seq.md
# mult8x8_seq

Sequential 8x8 unsigned multiplier. It computes the 16-bit product over four clock cycles from four 4x4 partial products, and presents a handshake to the datapath master. It also drives a 3-bit step code that feeds the seven-segment display decoder, which shows the current step (0–3) or a non-numeric glyph for idle/done.

## Interface
Parameters:
- none; widths are fixed at 8-bit operands, 16-bit product and 3-bit step code.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  request pulse. Sampled only in IDLE or DONE.
- `a`  in  8  multiplicand. Captured when `start` is accepted.
- `b`  in  8  multiplier. Captured when `start` is accepted.
- `product`  out  16  accumulated result. Valid while `done`=1.
- `done`  out  1  high in DONE state.
- `busy`  out  1  high in CALC state.
- `binary`  out  3  step code to the segment decoder.

## Operation
- FSM states: IDLE, CALC, DONE. A 2-bit step counter `cnt` is used in CALC.
- IDLE or DONE with `start`=1 at an edge:
  - latch `a` and `b`;
  - clear the accumulator;
  - set `cnt`=0;
  - go to CALC.
- IDLE or DONE with `start`=0: hold state. DONE holds `product`.
- CALC, each edge: add one partial product, then increment `cnt`. The partial product is selected from the latched operands:
  - `cnt`=0: a[3:0]*b[3:0], added at shift 0.
  - `cnt`=1: a[7:4]*b[3:0], added at shift 4.
  - `cnt`=2: a[3:0]*b[7:4], added at shift 4.
  - `cnt`=3: a[7:4]*b[7:4], added at shift 8.
- CALC with `cnt`=3: after the add, go to DONE.
- Arithmetic:
  - each partial product is 8 bits, zero-extended to 16 bits before shifting;
  - the accumulator is 16 bits and cannot overflow (maximum 0xFE01);
  - no carry-out bit is needed.
- `start` during CALC is ignored; the operation in flight completes unchanged. Changes to `a`/`b` after acceptance have no effect.
- Step code `binary`:
  - CALC: {1'b0, `cnt`}, giving 000, 001, 010, 011;
  - IDLE: 3'b100;
  - DONE: 3'b101.
  - Both 1xx codes render as the decoder's default glyph.
- `product` shows the running accumulator in every state. It is only guaranteed correct while `done`=1.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE, `cnt`=0;
  - `product`=16'h0000, `done`=0, `busy`=0;
  - `binary`=3'b100;
  - latched operands 0.
- Reset asserted mid-CALC aborts the operation; the accumulator clears.
- Reset release: the first active edge with `rst_n`=1 may accept `start`.
- Latency: `start` is sampled at edge E0. `busy`=1 from E0 to E4; `done`=1 and the final `product` appear after E4. This is four cycles of compute.
- Back-to-back: `start`=1 in DONE at edge En gives `done`=0 and `busy`=1 after En, with no idle cycle. Throughput is one result per 5 cycles including the DONE cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- `binary` changes only on clock edges. The segment decoder is combinational downstream, adding no cycles.

## Structure
- Shared package `mult_pkg` holds:
  - the state encoding (IDLE, CALC, DONE);
  - step-code constants (CODE_IDLE=3'b100, CODE_DONE=3'b101);
  - width constants (OP_W=8, NIB_W=4, PROD_W=16).
- One sub-module: `mult4x4`, a combinational 4x4→8 unsigned multiplier. It is instantiated once and fed by nibble muxes selected by `cnt`.
- The shift amount (0/4/8) is derived from `cnt` inside the top level with a small mux. The accumulator add is in the top level.
- Expected size is 150–250 lines including `mult4x4`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, release → `product`=0000, `done`=0, `busy`=0, `binary`=100. Assert `rst_n` mid-CALC (`cnt`=2) → all outputs return to reset values immediately.
- a=8'h12, b=8'h34, pulse `start` → `binary` is 000, 001, 010, 011 on successive cycles; then `done`=1, `product`=16'h03A8, `binary`=101.
- a=8'hFF, b=8'hFF → `product`=16'hFE01 after four CALC cycles, with no overflow.
- a=8'h00, b=8'hA7 → `product`=16'h0000 with `done`=1. Then a=8'h01, b=8'h01 → `product`=16'h0001.
- `start` re-pulsed at `cnt`=1 with a=8'hFF, b=8'hFF while computing 8'h12*8'h34 → ignored; result 16'h03A8 and latency unchanged.
- Back-to-back: `start`=1 in the DONE cycle with a=8'h10, b=8'h10 → `done` drops next cycle; 4 cycles later `product`=16'h0100.
